// File: rtl/led_blink_bank_if.sv
// Control and status bundle for the LED blink bank.
// Master drives mode/duty/enables; slave returns LEDs and counter state.
`timescale 1ns/1ps
interface led_blink_bank_if #(
  parameter int CHANNELS  = 8,
  parameter int BITS      = 8,
  parameter int LOG2DELAY = 21
);
  localparam int CNT_W = BITS + LOG2DELAY;
  localparam int TAP_W = $clog2(CNT_W);

  logic                      en;
  logic                      clr;
  logic [2*CHANNELS-1:0]     mode;
  logic [TAP_W*CHANNELS-1:0] tap_sel;
  logic [BITS*CHANNELS-1:0]  duty;
  logic [CHANNELS-1:0]       led;
  logic                      wrap;
  logic [CNT_W-1:0]          count;

  modport master (
    output en, clr, mode, tap_sel, duty,
    input  led, wrap, count
  );

  modport slave (
    input  en, clr, mode, tap_sel, duty,
    output led, wrap, count
  );
endinterface

// File: rtl/led_blink_bank.sv
// Multi-channel LED driver: shared free-running counter feeding
// per-channel off / blink / inverted blink / PWM outputs.
`timescale 1ns/1ps
module led_blink_bank #(
  parameter int CHANNELS  = 8,
  parameter int BITS      = 8,
  parameter int LOG2DELAY = 21
) (
  input  logic            clk,
  input  logic            rst,
  led_blink_bank_if.slave bus
);
  localparam int CNT_W = BITS + LOG2DELAY;
  localparam int TAP_W = $clog2(CNT_W);

  logic [CNT_W-1:0]    cnt_q;
  logic                wrap_q;
  logic [CHANNELS-1:0] led_q;
  logic [CHANNELS-1:0] led_d;
  logic [BITS-1:0]     dl_q [CHANNELS];
  logic [TAP_W-1:0]    tap  [CHANNELS];
  logic [BITS-1:0]     phase;
  logic                phase_end;
  logic                dl_load;

  assign phase     = cnt_q[BITS-1:0];
  assign phase_end = &phase;
  // Duty only moves at a period boundary so PWM never glitches
  assign dl_load   = bus.clr | (bus.en & phase_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else if (bus.clr) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= bus.en & (&cnt_q);
      if (bus.en) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++)
        dl_q[i] <= '0;
    end else if (dl_load) begin
      for (int i = 0; i < CHANNELS; i++)
        dl_q[i] <= bus.duty[i*BITS +: BITS];
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      tap[i] = bus.tap_sel[i*TAP_W +: TAP_W];
      if (32'(bus.tap_sel[i*TAP_W +: TAP_W]) >= 32'(CNT_W))
        tap[i] = TAP_W'(CNT_W - 1);
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      unique case (bus.mode[2*i +: 2])
        2'b00: led_d[i] = 1'b0;
        2'b01: led_d[i] = cnt_q[tap[i]];
        2'b10: led_d[i] = (phase < dl_q[i]);
        2'b11: led_d[i] = ~cnt_q[tap[i]];
        default: led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_q <= '0;
    else     led_q <= led_d;
  end

  assign bus.led   = led_q;
  assign bus.wrap  = wrap_q;
  assign bus.count = cnt_q;
endmodule

// File: doc/led_blink_bank.md
Name: led_blink_bank

Overview:
- Parametrised multi-channel LED driver for board bring-up and clock-tree test cases.
- One shared free-running counter feeds CHANNELS independent outputs.
- Each output is set per channel to one of four modes: off, blink from a chosen counter tap, inverted blink, or PWM dimming.
- Sits downstream of a PLL or a board clock; `en` is normally tied to the PLL lock so counting starts only on a stable clock.

Parameters:
- CHANNELS, 8, number of LED outputs.
- BITS, 8, PWM resolution; also the width of each duty field.
- LOG2DELAY, 21, extra prescale bits above BITS.
- CNT_W, BITS+LOG2DELAY, shared counter width (derived; do not override).
- TAP_W, $clog2(CNT_W), width of each per-channel tap-select field (derived).

Ports:
- clk  in  1  single clock; all state is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  counter advance enable (PLL lock or user enable).
- clr  in  1  synchronous clear of the counter and PWM state.
- mode  in  2*CHANNELS  per-channel mode, channel i at [2i+1:2i]. Encodings: 00 off, 01 blink, 10 pwm, 11 inverted blink.
- tap_sel  in  TAP_W*CHANNELS  per-channel counter bit index used in blink modes.
- duty  in  BITS*CHANNELS  per-channel PWM duty.
- led  out  CHANNELS  registered LED outputs.
- wrap  out  1  one-cycle pulse on counter wrap.
- count  out  CNT_W  current counter value.

Behaviour:
- Reset (async, rst=1):
  - count=0, led=0, wrap=0, all latched duties=0.
  - Release is synchronous to the next clk edge in effect; there is no internal synchronizer.
- Counter:
  - clr=1 gives count<=0 next edge, wrap<=0. clr has priority over en.
  - Otherwise, en=1 gives count<=count+1, modulo 2^CNT_W.
  - en=0 holds count.
- wrap:
  - Goes to 1 for exactly one cycle in the cycle after count goes from all-ones to 0 with en=1.
  - A clr at all-ones does not raise wrap.
- Tap select:
  - Any value >= CNT_W is saturated to CNT_W-1.
- PWM phase and period:
  - phase = count[BITS-1:0].
  - The PWM period is 2^BITS cycles of en=1.
- Duty latching:
  - Each channel has a latched duty register, dl[i].
  - dl[i] loads duty[i] when en=1 and phase is all-ones, so the new duty takes effect from phase 0.
  - dl[i] also loads duty[i] on clr. Otherwise dl[i] holds, so mid-period duty changes never glitch the output.
- LED output, led[i] registered, with one-cycle latency from count:
  - mode 00: led[i]<=0.
  - mode 01: led[i]<=count[tap_i].
  - mode 11: led[i]<=~count[tap_i].
  - mode 10: led[i]<=(phase < dl[i]).
    - dl=0 means always off.
    - dl=2^BITS-1 means on for 2^BITS-1 of 2^BITS cycles.
- Mode and tap_sel changes:
  - Take effect on the next edge with no gating. Only duty is period-aligned.
- en=0 behaviour:
  - led keeps updating from the frozen count, so outputs are static apart from mode and tap changes.
- Simultaneous clr and phase all-ones:
  - clr wins: count=0, dl=duty, no wrap.
- Reset mid-period:
  - All state returns to its reset values immediately; no partial PWM period survives.

Test Plan:
All scenarios use CHANNELS=2, BITS=4, LOG2DELAY=2 (CNT_W=6, TAP_W=3).

1. Reset and counting:
   - Stimulus: rst=1 for 3 cycles, then rst=0, en=1 for 70 cycles.
   - Required: count=0 and led=0 during reset. count reads 63 at cycle 63 after release. wrap=1 for one cycle only, in the cycle after count goes 63 to 0. count continues 1, 2, …
2. Blink taps:
   - Stimulus: ch0 mode=01 tap=2; ch1 mode=11 tap=7 (saturates to 5).
   - Required: led[0] toggles every 4 cycles. led[1]=~count[5], one cycle behind count.
3. PWM duty:
   - Stimulus: ch0 mode=10 duty=5.
   - Required: led[0] high for exactly 5 of every 16 cycles. With duty=0, led[0] is constantly 0. With duty=15, led[0] is high 15 of 16 cycles.
4. Duty change mid-period:
   - Stimulus: duty changes from 5 to 12 at phase=3.
   - Required: the current period still shows 5 high cycles; the next period, starting at phase 0, shows 12.
5. en/clr interaction:
   - Stimulus: en=0 at count=20 for 10 cycles, then clr=1 and en=1 together at count=63.
   - Required: count holds 20 while en=0. At the clr edge, count goes to 0, no wrap pulse, and dl takes the current duty.
6. Async reset mid-run:
   - Stimulus: assert rst between clock edges at count=37 with PWM active.
   - Required: led, count, wrap and dl go to 0 immediately, without waiting for a clk edge.
